ram_dma: RTL and testbench

// - Block-transfer initiator on the 256x16 RAM port (rw/adrs/din/dout); drives the RAM in place of the core during bulk ops.
// - Executes one command at a time: COPY bytes src->dst, FILL a range with a constant, SUM (checksum) a range.
// - Sits beside the core; the top level muxes the RAM port to this block while busy=1.

---
 rtl/ram_dma_pkg.sv | 23 ++
 rtl/ram_dma_ptr.sv | 33 +++
 rtl/ram_dma.sv | 150 +++++++++++++++
 tb/tb_ram_dma.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dma_pkg.sv
// Shared definitions for the RAM block-transfer engine: default widths,
// command op codes and FSM state encodings.
package ram_dma_pkg;
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam int DEF_RW = 16;

    typedef enum logic [1:0] {
        OP_COPY = 2'b00,
        OP_FILL = 2'b01,
        OP_SUM  = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_FILL = 3'd3,
        ST_SUM  = 3'd4,
        ST_DONE = 3'd5
    } state_e;
endpackage

// File: rtl/ram_dma_ptr.sv
// Loadable address pointer: load has priority over increment; wraps mod 2**AW.
module ram_dma_ptr #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] ptr
);
    logic [AW-1:0] ptr_d;
    logic [AW-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/ram_dma.sv
// Block-transfer initiator for the shared RAM port: COPY, FILL and SUM over
// wrapping address ranges, one command at a time.
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_fill,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] sum,
    output logic          ram_rw,
    output logic [AW-1:0] ram_adrs,
    output logic [DW-1:0] ram_din,
    input  logic [RW-1:0] ram_dout
);
    state_e        state_d, state_q;
    logic [AW-1:0] cnt_d, cnt_q;
    logic [DW-1:0] hold_d, hold_q;
    logic [DW-1:0] fill_d, fill_q;
    logic [RW-1:0] sum_d, sum_q;
    logic [AW-1:0] src_ptr, dst_ptr;
    logic          accept;
    logic          last_word;

    assign accept    = cmd_valid && (state_q == ST_IDLE);
    assign last_word = (cnt_q == AW'(1));

    ram_dma_ptr #(.AW(AW)) u_src_ptr (
        .clk      (clk),
        .clr      (clr),
        .load     (accept),
        .load_val (cmd_src),
        .inc      ((state_q == ST_RD) || (state_q == ST_SUM)),
        .ptr      (src_ptr)
    );

    ram_dma_ptr #(.AW(AW)) u_dst_ptr (
        .clk      (clk),
        .clr      (clr),
        .load     (accept),
        .load_val (cmd_dst),
        .inc      ((state_q == ST_WR) || (state_q == ST_FILL)),
        .ptr      (dst_ptr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        fill_d  = fill_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cnt_d  = cmd_len;
                    fill_d = cmd_fill;
                    if ((cmd_len == '0) || (op_e'(cmd_op) == OP_RSV)) begin
                        state_d = ST_DONE;
                    end else begin
                        case (op_e'(cmd_op))
                            OP_COPY: state_d = ST_RD;
                            OP_FILL: state_d = ST_FILL;
                            default: state_d = ST_SUM;
                        endcase
                    end
                    // The accumulator restarts only for SUM; other ops leave the last result visible.
                    if (op_e'(cmd_op) == OP_SUM) begin
                        sum_d = '0;
                    end
                end
            end
            ST_RD: begin
                hold_d  = ram_dout[DW-1:0];
                state_d = ST_WR;
            end
            ST_WR: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = last_word ? ST_DONE : ST_RD;
            end
            ST_FILL: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = last_word ? ST_DONE : ST_FILL;
            end
            ST_SUM: begin
                sum_d   = sum_q + ram_dout;
                cnt_d   = cnt_q - 1'b1;
                state_d = last_word ? ST_DONE : ST_SUM;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            fill_q  <= fill_d;
            sum_q   <= sum_d;
        end
    end

    // RAM-side signals depend only on flops, so clr silences the port without a clock.
    always_comb begin
        ram_rw   = 1'b0;
        ram_adrs = '0;
        ram_din  = '0;
        case (state_q)
            ST_RD, ST_SUM: ram_adrs = src_ptr;
            ST_WR: begin
                ram_rw   = 1'b1;
                ram_adrs = dst_ptr;
                ram_din  = hold_q;
            end
            ST_FILL: begin
                ram_rw   = 1'b1;
                ram_adrs = dst_ptr;
                ram_din  = fill_q;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
endmodule

// File: tb/tb_ram_dma.sv
// Scoreboard bench for ram_dma against a behavioural 256x16 RAM model.
module tb_ram_dma;
    import ram_dma_pkg::*;

    logic        clk;
    logic        clr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_src;
    logic [7:0]  cmd_dst;
    logic [7:0]  cmd_len;
    logic [7:0]  cmd_fill;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        ram_rw;
    logic [7:0]  ram_adrs;
    logic [7:0]  ram_din;
    logic [15:0] ram_dout;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        string            name;
        int               lat;
        int               writes;
        logic [15:0]      sum;
        int               n;
        logic [3:0][7:0]  a;
        logic [3:0][15:0] d;
    } exp_t;

    exp_t sb[$];

    ram_dma dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .cmd_fill  (cmd_fill),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .ram_rw    (ram_rw),
        .ram_adrs  (ram_adrs),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // RAM model: preset contents, posedge write of {00,din}, combinational read.
    assign ram_dout = mem[ram_adrs];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hBEEF;
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 16'h00A1 + 16'(i);
        mem[8'h00] = 16'hFFFF;
        mem[8'h01] = 16'h0002;
        mem[8'h02] = 16'h0010;
        mem[8'h20] = 16'h0007;
        for (int i = 0; i < 8; i++) mem[8'h80 + i] = 16'h1230 + 16'(i);
        forever begin
            @(posedge clk);
            if (ram_rw) mem[ram_adrs] <= {8'h00, ram_din};
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic push(input string name, input int lat, input int writes,
                        input logic [15:0] s, input int n,
                        input logic [3:0][7:0] a, input logic [3:0][15:0] d);
        exp_t e;
        e.name   = name;
        e.lat    = lat;
        e.writes = writes;
        e.sum    = s;
        e.n      = n;
        e.a      = a;
        e.d      = d;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                         input logic [7:0] len, input logic [7:0] fill);
        bit ok;
        @(posedge clk);
        #2;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got cmd_ready=0, expected 1 within 300 cycles");
        end
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && cmd_ready && !cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_rw"},    32'(ram_rw),    32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
        check({tag, "_done"},      32'(done),      32'h0);
        check({tag, "_sum"},       32'(sum),       32'h0);
        check({tag, "_ram_adrs"},  32'(ram_adrs),  32'h0);
        check({tag, "_ram_din"},   32'(ram_din),   32'h0);
    endtask

    // Monitor: latency, write count, sum and RAM contents checked on each done pulse.
    initial begin
        int   acc;
        int   wcnt;
        exp_t e;
        acc  = 0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!clr) begin
                if (ram_rw) wcnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected no command pending");
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_latency"}, 32'(cyc - acc + 1), 32'(e.lat));
                        check({e.name, "_writes"},  32'(wcnt),          32'(e.writes));
                        check({e.name, "_sum"},     32'(sum),           32'(e.sum));
                        for (int i = 0; i < e.n; i++)
                            check($sformatf("%s_mem%02h", e.name, e.a[i]), 32'(mem[e.a[i]]), 32'(e.d[i]));
                        $display("txn %s: done latency=%0d writes=%0d sum=%04h", e.name, cyc - acc + 1, wcnt, sum);
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    acc  = cyc + 1;
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        bit found;
        clr       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_src   = 8'h00;
        cmd_dst   = 8'h00;
        cmd_len   = 8'h00;
        cmd_fill  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        $display("txn reset: outputs idle");
        @(posedge clk);
        #2;
        clr = 1'b0;

        push("copy", 9, 4, 16'h0000, 4,
             {8'h43, 8'h42, 8'h41, 8'h40}, {16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1});
        issue(OP_COPY, 8'h10, 8'h40, 8'd4, 8'h00);

        push("sum", 4, 0, 16'h0011, 1,
             {8'h00, 8'h00, 8'h00, 8'h00}, {16'h0, 16'h0, 16'h0, 16'hFFFF});
        issue(OP_SUM, 8'h00, 8'h00, 8'd3, 8'h00);

        push("fill_wrap", 4, 3, 16'h0011, 4,
             {8'h01, 8'h00, 8'hFF, 8'hFE}, {16'h0002, 16'h005A, 16'h005A, 16'h005A});
        issue(OP_FILL, 8'h00, 8'hFE, 8'd3, 8'h5A);

        push("copy_overlap", 7, 3, 16'h0011, 4,
             {8'h24, 8'h23, 8'h22, 8'h21}, {16'hBEEF, 16'h0007, 16'h0007, 16'h0007});
        issue(OP_COPY, 8'h20, 8'h21, 8'd3, 8'h00);

        push("copy_len0", 1, 0, 16'h0011, 1,
             {8'h00, 8'h00, 8'h00, 8'h30}, {16'h0, 16'h0, 16'h0, 16'hBEEF});
        issue(OP_COPY, 8'h20, 8'h30, 8'd0, 8'h00);

        push("reserved_op", 1, 0, 16'h0011, 1,
             {8'h00, 8'h00, 8'h00, 8'h50}, {16'h0, 16'h0, 16'h0, 16'hBEEF});
        issue(OP_RSV, 8'h20, 8'h50, 8'd5, 8'h33);

        wait_drain();

        // Abort an 8-word COPY while it writes word 2.
        issue(OP_COPY, 8'h80, 8'hC0, 8'd8, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ram_rw && ram_adrs == 8'hC2) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL abort_trigger: got no write to C2, expected one within 100 cycles");
        end
        #1;
        clr = 1'b1;
        #1;
        check_reset_outputs("clr_async");
        @(negedge clk);
        check("clr_hold_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #2;
        clr = 1'b0;
        check("abort_memC0", 32'(mem[8'hC0]), 32'h0030);
        check("abort_memC1", 32'(mem[8'hC1]), 32'h0031);
        check("abort_memC2", 32'(mem[8'hC2]), 32'hBEEF);
        $display("txn abort: copy aborted at word 2");

        push("fill_after_clr", 2, 1, 16'h0000, 2,
             {8'h00, 8'h00, 8'hC3, 8'hC2}, {16'h0, 16'h0, 16'hBEEF, 16'h0077});
        issue(OP_FILL, 8'h00, 8'hC2, 8'd1, 8'h77);

        wait_drain();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
